clock_ui_ctrl: RTL and testbench
================================

# clock_ui_ctrl

Control/timing hub of the VGA clock display. It generates 640x480@72 Hz VGA sync and pixel coordinates from the 31.5 MHz pixel clock. It turns three push-buttons into accelerating auto-repeat adjust pulses, ticked once per frame. It also decodes the SPI byte stream into register write/read commands for the time-keeping logic.

## Interface
Parameters:
- MIN_COUNT, 2: shortest auto-repeat interval, in frames.
- DEC_COUNT, 1: interval decrement applied after each repeat.
- MAX_COUNT, 16: initial auto-repeat interval, in frames.

Ports:
- clk  in  1  pixel clock, 31.5 MHz; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- adj_hrs, adj_min, adj_sec  in  1 each  button levels, high = pressed; already synchronised upstream.
- spi_data  in  8  received SPI byte.
- spi_data_valid  in  1  one-cycle strobe qualifying spi_data.
- hsync, vsync  out  1  active-low syncs.
- x_px, y_px  out  10  current pixel column/row.
- activevideo  out  1  high inside the 640x480 visible area.
- adj_hrs_pulse, adj_min_pulse, adj_sec_pulse  out  1  one-cycle adjust pulses.
- cmd_write, cmd_read  out  1  one-cycle command strobes.
- cmd_addr  out  8  register address of last command.
- cmd_write_data  out  8  data of last write.

## Operation
Sync generator:
- x_px counts 0..831 and wraps to 0. y_px increments when x_px wraps and counts 0..519, wrapping to 0.
- Horizontal timing: 640 active, 24 front porch, 40 sync, 128 back porch.
- Vertical timing: 480 active, 9 front porch, 3 sync, 28 back porch.
- hsync = 0 iff 664 <= x_px <= 703. vsync = 0 iff 489 <= y_px <= 491.
- activevideo = (x_px < 640) && (y_px < 480).

Button repeat, one identical channel per button:
- frame_tick = (x_px == 0 && y_px == 0).
- Per-channel state: count (0..MAX_COUNT-1) and interval (MIN_COUNT..MAX_COUNT).
- On frame_tick with the button low: count <= 0, interval <= MAX_COUNT.
- On frame_tick with the button high:
  - if count == 0, fire the pulse;
  - if count == interval-1: count <= 0 and interval <= max(interval-DEC_COUNT, MIN_COUNT);
  - otherwise count <= count+1.
- Holding a button gives pulses at frame ticks 0, 16, 31, 45, … The spacing shrinks by 1 each time until it settles at 2 frames.
- Button level is ignored on cycles without frame_tick.

Command parser, bytes consumed only on spi_data_valid:
- FSM states: IDLE, ADDR, DATA.
- IDLE: byte 0x01 → ADDR, flagged as write. Byte 0x02 → ADDR, flagged as read. Any other byte is ignored and the FSM stays in IDLE.
- ADDR: latch cmd_addr. For a read, strobe cmd_read and return to IDLE. For a write, go to DATA.
- DATA: latch cmd_write_data, strobe cmd_write, return to IDLE.
- No framing/resync beyond reset. An interrupted command resumes with the next byte.

## Timing
- Reset values:
  - x_px = y_px = 0, so hsync = 1, vsync = 1, activevideo = 1 on the first cycle after reset.
  - All pulses and strobes 0; cmd_addr = cmd_write_data = 0; FSM in IDLE.
  - Button counters 0 and intervals MAX_COUNT.
- Counters are registered. hsync, vsync and activevideo decode the current counters with zero latency.
- Adjust pulses are registered: high exactly one clk cycle, the cycle after the frame_tick that fired them.
- cmd_read / cmd_write are registered: high exactly one cycle, the cycle after the final byte's valid. cmd_addr and cmd_write_data are valid on that same cycle and held until the next command overwrites them.
- Reset mid-command returns the FSM to IDLE. Reset mid-frame restarts at (0,0).
- Back-to-back valid bytes on consecutive cycles must be accepted.

## Test plan
- Reset, run 832*520 cycles → exactly one hsync low run of 40 cycles per line. Check vsync low for 3 lines starting at y_px = 489, and activevideo high for 640*480 cycles per frame.
- Hold adj_sec high from reset for 50 frames → adj_sec_pulse at frame ticks 0, 16, 31, 45. Each pulse is 1 cycle wide, one cycle after the tick.
- Hold adj_min for 200 frames → pulse spacing decreases to 2 frames and stays 2. Release for one tick, re-press → next pulse is immediate, followed by a 16-frame gap.
- Send bytes 0x01, 0x05, 0x3A → cmd_write high for 1 cycle with cmd_addr = 0x05 and cmd_write_data = 0x3A; cmd_read stays 0.
- Send 0x02, 0x07 → cmd_read 1-cycle strobe with cmd_addr = 0x07. A preceding stray 0xFF byte is ignored.
- Send 0x01, 0x05, assert reset, then send 0x01, 0x06, 0x11 → single cmd_write with cmd_addr = 0x06 and data 0x11.

Source files
------------

// File: rtl/clock_ui_ctrl_if.sv
// Byte-stream command bus between the SPI receiver and the clock UI controller.
// The master supplies received bytes; the slave returns decoded register commands.
interface clock_ui_ctrl_if;
    logic [7:0] spi_data;
    logic       spi_data_valid;
    logic       cmd_write;
    logic       cmd_read;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_write_data;

    modport master (
        output spi_data,
        output spi_data_valid,
        input  cmd_write,
        input  cmd_read,
        input  cmd_addr,
        input  cmd_write_data
    );

    modport slave (
        input  spi_data,
        input  spi_data_valid,
        output cmd_write,
        output cmd_read,
        output cmd_addr,
        output cmd_write_data
    );
endinterface

// File: rtl/clock_ui_ctrl.sv
// VGA clock display control hub: sync/pixel counters, per-frame button auto-repeat
// and SPI byte-stream command decoding, all on the pixel clock.
module clock_ui_ctrl #(
    parameter int MIN_COUNT = 2,
    parameter int DEC_COUNT = 1,
    parameter int MAX_COUNT = 16,
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 128,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 9,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adj_hrs,
    input  logic              adj_min,
    input  logic              adj_sec,
    clock_ui_ctrl_if.slave    spi,
    output logic              hsync,
    output logic              vsync,
    output logic [9:0]        x_px,
    output logic [9:0]        y_px,
    output logic              activevideo,
    output logic              adj_hrs_pulse,
    output logic              adj_min_pulse,
    output logic              adj_sec_pulse
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    // ------------------------------------------------------------------
    // Pixel / line counters
    // ------------------------------------------------------------------
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;

    always_comb begin
        x_next = x_reg + 10'd1;
        y_next = y_reg;
        if (x_reg == H_LAST) begin
            x_next = '0;
            y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign x_px        = x_reg;
    assign y_px        = y_reg;
    assign hsync       = !((x_reg >= HS_FIRST) && (x_reg <= HS_LAST));
    assign vsync       = !((y_reg >= VS_FIRST) && (y_reg <= VS_LAST));
    assign activevideo = (x_reg < H_VIS) && (y_reg < V_VIS);

    logic frame_tick;
    assign frame_tick = (x_reg == '0) && (y_reg == '0);

    // ------------------------------------------------------------------
    // Button auto-repeat, one channel per button (0 = sec, 1 = min, 2 = hrs)
    // ------------------------------------------------------------------
    localparam int CW = $clog2(MAX_COUNT + MIN_COUNT + DEC_COUNT + 1);
    localparam logic [CW-1:0] MAX_V   = CW'(MAX_COUNT);
    localparam logic [CW-1:0] MIN_V   = CW'(MIN_COUNT);
    localparam logic [CW-1:0] DEC_V   = CW'(DEC_COUNT);
    localparam logic [CW-1:0] FLOOR_V = CW'(MIN_COUNT + DEC_COUNT);

    logic [2:0] btn_lvl;
    assign btn_lvl = {adj_hrs, adj_min, adj_sec};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic [CW-1:0] count_reg, count_next;
            logic [CW-1:0] interval_reg, interval_next;
            logic          pulse_reg, pulse_next;

            always_comb begin
                count_next    = count_reg;
                interval_next = interval_reg;
                pulse_next    = 1'b0;
                if (frame_tick) begin
                    if (!btn_lvl[gi]) begin
                        count_next    = '0;
                        interval_next = MAX_V;
                    end else begin
                        pulse_next = (count_reg == '0);
                        if (count_reg + 1'b1 == interval_reg) begin
                            // interval shrinks toward MIN_COUNT, never below it
                            count_next    = '0;
                            interval_next = (interval_reg < FLOOR_V) ? MIN_V
                                                                     : interval_reg - DEC_V;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg    <= '0;
                    interval_reg <= MAX_V;
                    pulse_reg    <= 1'b0;
                end else begin
                    count_reg    <= count_next;
                    interval_reg <= interval_next;
                    pulse_reg    <= pulse_next;
                end
            end
        end
    endgenerate

    assign adj_sec_pulse = g_btn[0].pulse_reg;
    assign adj_min_pulse = g_btn[1].pulse_reg;
    assign adj_hrs_pulse = g_btn[2].pulse_reg;

    // ------------------------------------------------------------------
    // SPI command parser
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] state_reg, state_next;
    logic       is_write_reg, is_write_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] data_reg, data_next;
    logic       wr_reg, wr_next;
    logic       rd_reg, rd_next;

    always_comb begin
        state_next    = state_reg;
        is_write_next = is_write_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        wr_next       = 1'b0;
        rd_next       = 1'b0;
        if (spi.spi_data_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (spi.spi_data == 8'h01) begin
                        state_next    = ST_ADDR;
                        is_write_next = 1'b1;
                    end else if (spi.spi_data == 8'h02) begin
                        state_next    = ST_ADDR;
                        is_write_next = 1'b0;
                    end
                end
                ST_ADDR: begin
                    addr_next = spi.spi_data;
                    if (is_write_reg) begin
                        state_next = ST_DATA;
                    end else begin
                        rd_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    data_next  = spi.spi_data;
                    wr_next    = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            is_write_reg <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            wr_reg       <= 1'b0;
            rd_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            is_write_reg <= is_write_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            wr_reg       <= wr_next;
            rd_reg       <= rd_next;
        end
    end

    assign spi.cmd_write      = wr_reg;
    assign spi.cmd_read       = rd_reg;
    assign spi.cmd_addr       = addr_reg;
    assign spi.cmd_write_data = data_reg;

endmodule

// File: tb/tb_clock_ui_ctrl.sv
// Self-checking bench for clock_ui_ctrl: a reduced-timing instance exercises every
// feature over many frames, a full 640x480 instance checks the first video lines.
module tb_clock_ui_ctrl;
    localparam int SH_A = 8, SH_F = 2, SH_S = 2, SH_B = 2;
    localparam int SV_A = 6, SV_F = 1, SV_S = 2, SV_B = 1;
    localparam int SHT = SH_A + SH_F + SH_S + SH_B;
    localparam int SVT = SV_A + SV_F + SV_S + SV_B;
    localparam int FRAME = SHT * SVT;
    localparam int MINC = 2, DECC = 1, MAXC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       adj_hrs, adj_min, adj_sec, zero_lvl;
    logic       hsync, vsync, activevideo;
    logic [9:0] x_px, y_px;
    logic       adj_hrs_pulse, adj_min_pulse, adj_sec_pulse;
    logic       f_hsync, f_vsync, f_active;
    logic [9:0] f_x, f_y;
    logic       f_hp, f_mp, f_sp;

    clock_ui_ctrl_if bus();
    clock_ui_ctrl_if fbus();

    clock_ui_ctrl #(
        .MIN_COUNT(MINC), .DEC_COUNT(DECC), .MAX_COUNT(MAXC),
        .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B)
    ) dut (
        .clk(clk), .reset(reset),
        .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
        .spi(bus.slave),
        .hsync(hsync), .vsync(vsync), .x_px(x_px), .y_px(y_px),
        .activevideo(activevideo),
        .adj_hrs_pulse(adj_hrs_pulse), .adj_min_pulse(adj_min_pulse),
        .adj_sec_pulse(adj_sec_pulse)
    );

    clock_ui_ctrl dut_full (
        .clk(clk), .reset(reset),
        .adj_hrs(zero_lvl), .adj_min(zero_lvl), .adj_sec(zero_lvl),
        .spi(fbus.slave),
        .hsync(f_hsync), .vsync(f_vsync), .x_px(f_x), .y_px(f_y),
        .activevideo(f_active),
        .adj_hrs_pulse(f_hp), .adj_min_pulse(f_mp), .adj_sec_pulse(f_sp)
    );

    int checks, errors;
    int k;

    // button reference: frames left until next pulse, and the gap after it
    int m_wait[3];
    int m_gap[3];
    int sec_ticks[$];
    int min_ticks[$];

    // command reference: bytes of the command being assembled
    logic [7:0] q[$];
    logic [7:0] m_addr, m_data;
    int n_wr, n_rd;
    logic [7:0] seen_addr, seen_data;

    task automatic cycle();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.spi_data_valid = 1'b0;
        adj_hrs = 0; adj_min = 0; adj_sec = 0;
        cycle();
        cycle();
        reset = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            m_wait[c] = 0;
            m_gap[c]  = MAXC;
        end
        q.delete();
        m_addr = 8'h00;
        m_data = 8'h00;
    endtask

    function automatic bit model_tick(input int c, input bit pressed);
        bit fire;
        fire = 1'b0;
        if (!pressed) begin
            m_wait[c] = 0;
            m_gap[c]  = MAXC;
        end else if (m_wait[c] == 0) begin
            fire      = 1'b1;
            m_wait[c] = m_gap[c] - 1;
            m_gap[c]  = (m_gap[c] - DECC < MINC) ? MINC : m_gap[c] - DECC;
        end else begin
            m_wait[c] = m_wait[c] - 1;
        end
        return fire;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (x_px !== 10'd0 || y_px !== 10'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", x_px, y_px); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || activevideo !== 1'b1) begin errors++; $display("FAIL reset_sync: got h%b v%b a%b expected h1 v1 a1", hsync, vsync, activevideo); end
        checks++; if ({adj_hrs_pulse, adj_min_pulse, adj_sec_pulse} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {adj_hrs_pulse, adj_min_pulse, adj_sec_pulse}); end
        checks++; if (bus.cmd_write !== 1'b0 || bus.cmd_read !== 1'b0) begin errors++; $display("FAIL reset_strobes: got w%b r%b expected w0 r0", bus.cmd_write, bus.cmd_read); end
        checks++; if (bus.cmd_addr !== 8'h00 || bus.cmd_write_data !== 8'h00) begin errors++; $display("FAIL reset_cmd_regs: got %h/%h expected 00/00", bus.cmd_addr, bus.cmd_write_data); end
        checks++; if (f_x !== 10'd0 || f_y !== 10'd0 || f_hsync !== 1'b1 || f_active !== 1'b1) begin errors++; $display("FAIL reset_full: got %0d,%0d h%b a%b expected 0,0 h1 a1", f_x, f_y, f_hsync, f_active); end
        // reset in the middle of a frame restarts at the origin
        for (int i = 0; i < 37 + $urandom_range(0, 200); i++) cycle();
        do_reset();
        checks++; if (x_px !== 10'd0 || y_px !== 10'd0 || f_x !== 10'd0 || f_y !== 10'd0) begin errors++; $display("FAIL reset_midframe: got %0d,%0d full %0d,%0d expected zeros", x_px, y_px, f_x, f_y); end
    endtask

    task automatic test_sync();
        int ex, ey, fx, fy, hl, av;
        bit eh, ev, ea, feh, fev, fea;
        do_reset();
        hl = 0;
        av = 0;
        for (int i = 0; i < 6 * 832; i++) begin
            ex = k % SHT;
            ey = (k / SHT) % SVT;
            eh = !(ex >= SH_A + SH_F && ex < SH_A + SH_F + SH_S);
            ev = !(ey >= SV_A + SV_F && ey < SV_A + SV_F + SV_S);
            ea = (ex < SH_A) && (ey < SV_A);
            checks++; if (x_px !== 10'(ex) || y_px !== 10'(ey)) begin errors++; $display("FAIL sync_xy k=%0d: got %0d,%0d expected %0d,%0d", k, x_px, y_px, ex, ey); end
            checks++; if (hsync !== eh || vsync !== ev || activevideo !== ea) begin errors++; $display("FAIL sync_decode k=%0d: got h%b v%b a%b expected h%b v%b a%b", k, hsync, vsync, activevideo, eh, ev, ea); end
            if (activevideo === 1'b1) av++;
            if (k % FRAME == FRAME - 1) begin
                checks++; if (av !== SH_A * SV_A) begin errors++; $display("FAIL sync_active_count: got %0d expected %0d", av, SH_A * SV_A); end
                av = 0;
            end
            fx = k % 832;
            fy = (k / 832) % 520;
            feh = !(fx >= 664 && fx <= 703);
            fev = !(fy >= 489 && fy <= 491);
            fea = (fx < 640) && (fy < 480);
            checks++; if (f_x !== 10'(fx) || f_y !== 10'(fy)) begin errors++; $display("FAIL full_xy k=%0d: got %0d,%0d expected %0d,%0d", k, f_x, f_y, fx, fy); end
            checks++; if (f_hsync !== feh || f_vsync !== fev || f_active !== fea) begin errors++; $display("FAIL full_decode k=%0d: got h%b v%b a%b expected h%b v%b a%b", k, f_hsync, f_vsync, f_active, feh, fev, fea); end
            if (f_hsync === 1'b0) hl++;
            if (fx == 831) begin
                checks++; if (hl !== 40) begin errors++; $display("FAIL full_hsync_len: got %0d expected 40", hl); end
                hl = 0;
            end
            cycle();
        end
    endtask

    // mode 0: hold sec; mode 1: hold min, release on tick 160; mode 2: random
    task automatic run_buttons(input int frames, input int mode);
        bit [2:0] lvl;
        bit [2:0] ep;
        int nt;
        do_reset();
        ep = 3'b000;
        lvl = (mode == 2) ? 3'($urandom) : 3'b000;
        sec_ticks.delete();
        min_ticks.delete();
        for (int i = 0; i < frames * FRAME; i++) begin
            checks++; if (adj_sec_pulse !== ep[0]) begin errors++; $display("FAIL sec_pulse k=%0d: got %b expected %b", k, adj_sec_pulse, ep[0]); end
            checks++; if (adj_min_pulse !== ep[1]) begin errors++; $display("FAIL min_pulse k=%0d: got %b expected %b", k, adj_min_pulse, ep[1]); end
            checks++; if (adj_hrs_pulse !== ep[2]) begin errors++; $display("FAIL hrs_pulse k=%0d: got %b expected %b", k, adj_hrs_pulse, ep[2]); end
            if (adj_sec_pulse === 1'b1) sec_ticks.push_back((k - 1) / FRAME);
            if (adj_min_pulse === 1'b1) min_ticks.push_back((k - 1) / FRAME);
            if (k % FRAME == 0) begin
                nt = k / FRAME;
                case (mode)
                    0: lvl = 3'b001;
                    1: lvl = (nt == 160) ? 3'b000 : 3'b010;
                    default: begin
                        for (int c = 0; c < 3; c++)
                            if ($urandom_range(0, 7) == 0) lvl[c] = ~lvl[c];
                    end
                endcase
                adj_sec = lvl[0]; adj_min = lvl[1]; adj_hrs = lvl[2];
                for (int c = 0; c < 3; c++) ep[c] = model_tick(c, lvl[c]);
            end else begin
                ep = 3'b000;
                if (mode == 2) begin
                    adj_sec = 1'($urandom); adj_min = 1'($urandom); adj_hrs = 1'($urandom);
                end
            end
            cycle();
        end
        adj_sec = 0; adj_min = 0; adj_hrs = 0;
    endtask

    task automatic test_sec_hold();
        int exp_t[4];
        exp_t = '{0, 16, 31, 45};
        run_buttons(50, 0);
        checks++; if (sec_ticks.size() !== 4) begin errors++; $display("FAIL sec_hold_count: got %0d expected 4", sec_ticks.size()); end
        for (int j = 0; j < 4 && j < sec_ticks.size(); j++) begin
            checks++; if (sec_ticks[j] !== exp_t[j]) begin errors++; $display("FAIL sec_hold_tick%0d: got %0d expected %0d", j, sec_ticks[j], exp_t[j]); end
        end
    endtask

    task automatic test_min_hold();
        int idx;
        run_buttons(180, 1);
        idx = -1;
        for (int j = 1; j < min_ticks.size(); j++) begin
            if (min_ticks[j - 1] >= 133 && min_ticks[j] < 160) begin
                checks++; if (min_ticks[j] - min_ticks[j - 1] !== 2) begin errors++; $display("FAIL min_min_gap at tick %0d: got %0d expected 2", min_ticks[j], min_ticks[j] - min_ticks[j - 1]); end
            end
        end
        for (int j = 0; j < min_ticks.size(); j++) if (min_ticks[j] == 161) idx = j;
        checks++; if (idx < 1 || min_ticks[idx - 1] !== 159) begin errors++; $display("FAIL min_repress_immediate: got index %0d expected pulse at 161 after 159", idx); end
        checks++; if (idx < 0 || idx + 1 >= min_ticks.size() || min_ticks[idx + 1] !== 177) begin errors++; $display("FAIL min_repress_gap: got %0d expected 177", (idx >= 0 && idx + 1 < min_ticks.size()) ? min_ticks[idx + 1] : -1); end
    endtask

    task automatic spi_step(input bit v, input logic [7:0] b);
        bit ewr, erd;
        bus.spi_data = b;
        bus.spi_data_valid = v;
        ewr = 0;
        erd = 0;
        if (v && !(q.size() == 0 && b != 8'h01 && b != 8'h02)) begin
            q.push_back(b);
            if (q.size() == 2) begin
                m_addr = b;
                if (q[0] == 8'h02) begin
                    erd = 1;
                    q.delete();
                end
            end else if (q.size() == 3) begin
                m_data = b;
                ewr = 1;
                q.delete();
            end
        end
        cycle();
        bus.spi_data_valid = 1'b0;
        checks++; if (bus.cmd_write !== ewr) begin errors++; $display("FAIL cmd_write k=%0d: got %b expected %b", k, bus.cmd_write, ewr); end
        checks++; if (bus.cmd_read !== erd) begin errors++; $display("FAIL cmd_read k=%0d: got %b expected %b", k, bus.cmd_read, erd); end
        checks++; if (bus.cmd_addr !== m_addr) begin errors++; $display("FAIL cmd_addr k=%0d: got %h expected %h", k, bus.cmd_addr, m_addr); end
        checks++; if (bus.cmd_write_data !== m_data) begin errors++; $display("FAIL cmd_write_data k=%0d: got %h expected %h", k, bus.cmd_write_data, m_data); end
        if (bus.cmd_write === 1'b1) begin n_wr++; seen_addr = bus.cmd_addr; seen_data = bus.cmd_write_data; end
        if (bus.cmd_read === 1'b1) begin n_rd++; seen_addr = bus.cmd_addr; end
    endtask

    task automatic test_cmd_write();
        do_reset();
        n_wr = 0; n_rd = 0;
        spi_step(1, 8'h01); spi_step(1, 8'h05); spi_step(1, 8'h3A);
        spi_step(0, 8'h00); spi_step(0, 8'h00);
        checks++; if (n_wr !== 1 || n_rd !== 0) begin errors++; $display("FAIL write_strobes: got w%0d r%0d expected w1 r0", n_wr, n_rd); end
        checks++; if (seen_addr !== 8'h05 || seen_data !== 8'h3A) begin errors++; $display("FAIL write_fields: got %h/%h expected 05/3a", seen_addr, seen_data); end
    endtask

    task automatic test_cmd_read();
        do_reset();
        n_wr = 0; n_rd = 0;
        spi_step(1, 8'hFF); spi_step(0, 8'h00); spi_step(1, 8'h02); spi_step(1, 8'h07);
        spi_step(0, 8'h00);
        checks++; if (n_rd !== 1 || n_wr !== 0) begin errors++; $display("FAIL read_strobes: got w%0d r%0d expected w0 r1", n_wr, n_rd); end
        checks++; if (seen_addr !== 8'h07) begin errors++; $display("FAIL read_addr: got %h expected 07", seen_addr); end
    endtask

    task automatic test_reset_mid_cmd();
        do_reset();
        n_wr = 0; n_rd = 0;
        spi_step(1, 8'h01); spi_step(1, 8'h05);
        do_reset();
        spi_step(1, 8'h01); spi_step(1, 8'h06); spi_step(1, 8'h11);
        spi_step(0, 8'h00);
        checks++; if (n_wr !== 1 || n_rd !== 0) begin errors++; $display("FAIL resetcmd_strobes: got w%0d r%0d expected w1 r0", n_wr, n_rd); end
        checks++; if (seen_addr !== 8'h06 || seen_data !== 8'h11) begin errors++; $display("FAIL resetcmd_fields: got %h/%h expected 06/11", seen_addr, seen_data); end
    endtask

    task automatic test_cmd_random();
        int r;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            b = (r < 3) ? 8'h01 : (r < 5) ? 8'h02 : 8'($urandom);
            spi_step($urandom_range(0, 9) < 7, b);
        end
    endtask

    initial begin
        checks = 0; errors = 0; k = 0;
        reset = 1'b1;
        zero_lvl = 1'b0;
        adj_hrs = 0; adj_min = 0; adj_sec = 0;
        bus.spi_data = 8'h00; bus.spi_data_valid = 1'b0;
        fbus.spi_data = 8'h00; fbus.spi_data_valid = 1'b0;
        test_reset();
        test_sync();
        test_sec_hold();
        test_min_hold();
        run_buttons(60, 2);
        test_cmd_write();
        test_cmd_read();
        test_reset_mid_cmd();
        test_cmd_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
